phase_dac_serializer: RTL and testbench
=======================================

PHASE_DAC_SERIALIZER -- requirements
Module: phase_dac_serializer

Interface
REQ-001 SHALL have parameter DAC_W, default 16, DAC word width in bits.
REQ-002 SHALL have parameter CLK_DIV, default 2, i_clk cycles per SCLK half-period (legal range 1..255).
REQ-003 SHALL have parameter CS_HOLD, default 4, minimum i_clk cycles o_dac_cs_n stays high between frames.
REQ-004 SHALL have port i_clk, input, 1 bit, sole clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port i_phaseRamp, input, 32 bits, feedback phase word from the phase ramp stage (unsigned, wraps).
REQ-007 SHALL have port i_ramp_sync, input, 1 bit, one-cycle update strobe qualifying i_phaseRamp.
REQ-008 SHALL have port i_dac_offset, input, 32 bits, offset added to the phase word before truncation.
REQ-009 SHALL have port i_dac_en, input, 1 bit; 0 blocks new frames.
REQ-010 SHALL have port o_dac_sclk, output, 1 bit, SPI clock, idle low.
REQ-011 SHALL have port o_dac_sdi, output, 1 bit, SPI data, MSB first.
REQ-012 SHALL have port o_dac_cs_n, output, 1 bit, active-low frame select.
REQ-013 SHALL have port o_busy, output, 1 bit, high from frame start until the CS_HOLD period ends.
REQ-014 SHALL have port o_done, output, 1 bit, one-cycle pulse at end of CS_HOLD.
REQ-015 SHALL have port o_overrun, output, 1 bit, sticky flag, set when a pending word is overwritten.
REQ-016 SHALL have port o_dac_word, output, DAC_W bits, last word shifted out.

Function
REQ-017 On i_ramp_sync=1, the block SHALL compute word = (i_phaseRamp + i_dac_offset) mod 2^32 and keep bits [31:32-DAC_W] (MSB-aligned truncation, no saturation).
REQ-018 States SHALL be IDLE, LOAD, SHIFT, HOLD.
REQ-019 A strobe in IDLE with i_dac_en=1 SHALL move the block to LOAD in the next cycle; LOAD lasts 1 cycle, asserts o_dac_cs_n=0 and o_busy=1, and loads the shift register.
REQ-020 In SHIFT, SDI SHALL update while SCLK is low, and SCLK SHALL rise after CLK_DIV cycles and fall after a further CLK_DIV cycles; DAC_W SCLK periods SHALL be sent.
REQ-021 After the last falling SCLK edge, o_dac_cs_n SHALL go high and the block SHALL enter HOLD for CS_HOLD cycles, then pulse o_done and return to IDLE; o_dac_word SHALL update at o_done.
REQ-022 Frame length from strobe to o_done SHALL be exactly 2 + 2*CLK_DIV*DAC_W + CS_HOLD cycles (DAC_W=16, CLK_DIV=2, CS_HOLD=4: 70 cycles).
REQ-023 A strobe while busy SHALL be stored in a one-deep pending register; a further strobe before it is consumed SHALL overwrite it and set o_overrun.
REQ-024 On IDLE entry with a pending word, LOAD SHALL start in the next cycle with the pending word, and the pending register SHALL clear.
REQ-025 A strobe in the same cycle the block returns to IDLE SHALL be taken directly, and an existing pending word SHALL be overwritten with o_overrun set.
REQ-026 i_dac_en=0 SHALL drop strobes and pending words but SHALL NOT abort a frame in progress.
REQ-027 o_overrun SHALL clear only on reset.

Reset
REQ-028 While i_rst=1, outputs SHALL be o_dac_sclk=0, o_dac_sdi=0, o_dac_cs_n=1, o_busy=0, o_done=0, o_overrun=0, o_dac_word=0; state SHALL be IDLE and the pending register empty.
REQ-029 Reset asserted mid-frame SHALL force o_dac_cs_n high asynchronously and abort the frame; no partial o_done SHALL be issued.

Structure
REQ-030 State encoding and default DAC_W/CLK_DIV/CS_HOLD constants SHALL reside in the shared fog package.
REQ-031 The SCLK divider/bit counter SHALL be one sub-module, spi_bit_timer, which emits sclk_rise, sclk_fall and last_bit strobes.

Verification
REQ-032 Reset release, then i_phaseRamp=0x12345678, offset=0, strobe: SDI bits SHALL read 0x1234 MSB first, o_done SHALL occur at cycle 70, and o_dac_word SHALL equal 0x1234.
REQ-033 i_phaseRamp=0xFFFF8000, offset=0x00010000, strobe: o_dac_word SHALL equal 0x0000 (wrap).
REQ-034 Strobe A, then strobe B at cycle 10: B SHALL start 1 cycle after A's o_done, and o_overrun SHALL stay 0.
REQ-035 Strobes A, B, C within one frame: the frame after A SHALL send C, and o_overrun SHALL be 1.
REQ-036 i_rst pulsed at cycle 20 of a frame: o_dac_cs_n SHALL be 1 immediately, no o_done SHALL occur, and the next strobe SHALL produce a full clean frame.
REQ-037 i_dac_en=0 with a strobe: no frame SHALL start; i_dac_en deasserted mid-frame: the frame SHALL complete normally.

Source files
------------

// File: rtl/phase_dac_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : phase_dac_serializer_pkg
//  Purpose  : Shared types and constants for the phase DAC serializer:
//             frame FSM state encoding, default DAC_W/CLK_DIV/CS_HOLD values
//             and the modular phase-plus-offset helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package phase_dac_serializer_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int c_DEF_DAC_W   = 16;
  localparam int c_DEF_CLK_DIV = 2;
  localparam int c_DEF_CS_HOLD = 4;
  localparam int c_PHASE_W     = 32;

  // Phase word plus offset, wrapping modulo 2^32 (carry out is discarded)
  function automatic logic [c_PHASE_W-1:0] phase_add(
    input logic [c_PHASE_W-1:0] a,
    input logic [c_PHASE_W-1:0] b
  );
    return a + b;
  endfunction

endpackage : phase_dac_serializer_pkg
`default_nettype wire

// File: rtl/phase_dac_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : phase_dac_serializer_if
//  Purpose  : Bundles the phase-word input, update strobe, enable, the SPI
//             DAC pins and the status outputs of the phase DAC serializer.
//  Ports    : (interface signals, named from the serializer's point of view)
//             i_phaseRamp  [31:0]  phase word from the ramp stage
//             i_ramp_sync          one-cycle strobe qualifying i_phaseRamp
//             i_dac_offset [31:0]  offset added before truncation
//             i_dac_en             0 blocks new frames
//             o_dac_sclk/o_dac_sdi/o_dac_cs_n  SPI pins
//             o_busy, o_done, o_overrun, o_dac_word[DAC_W-1:0]  status
//  Modports : slave  - the serializer
//             master - the block feeding the serializer
//  Revision : 1.0 - initial release
// ============================================================================
interface phase_dac_serializer_if
  import phase_dac_serializer_pkg::*;
#(
  parameter int DAC_W = c_DEF_DAC_W
);

  logic [31:0]      i_phaseRamp;
  logic             i_ramp_sync;
  logic [31:0]      i_dac_offset;
  logic             i_dac_en;
  logic             o_dac_sclk;
  logic             o_dac_sdi;
  logic             o_dac_cs_n;
  logic             o_busy;
  logic             o_done;
  logic             o_overrun;
  logic [DAC_W-1:0] o_dac_word;

  modport slave (
    input  i_phaseRamp, i_ramp_sync, i_dac_offset, i_dac_en,
    output o_dac_sclk, o_dac_sdi, o_dac_cs_n, o_busy, o_done, o_overrun,
           o_dac_word
  );

  modport master (
    output i_phaseRamp, i_ramp_sync, i_dac_offset, i_dac_en,
    input  o_dac_sclk, o_dac_sdi, o_dac_cs_n, o_busy, o_done, o_overrun,
           o_dac_word
  );

endinterface : phase_dac_serializer_if
`default_nettype wire

// File: rtl/phase_dac_serializer_spi_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_bit_timer
//  Purpose  : SCLK divider and bit counter for the DAC serializer. While
//             i_run is high it produces a low half-period of CLK_DIV cycles
//             followed by a high half-period of CLK_DIV cycles, DAC_W times.
//             Strobes are combinational and announce the SCLK edge that the
//             parent registers on the next i_clk edge.
//  Ports    : i_clk, i_rst      clock, asynchronous active-high reset
//             i_run             count while high, clear while low
//             o_sclk_rise       SCLK goes high at the next edge
//             o_sclk_fall       SCLK goes low at the next edge
//             o_last_bit        o_sclk_fall of the final bit of the frame
//  Revision : 1.0 - initial release
// ============================================================================
module spi_bit_timer #(
  parameter int DAC_W   = 16,
  parameter int CLK_DIV = 2     // legal range 1..255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_last_bit
);

  localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_BIT_W = (DAC_W > 1) ? $clog2(DAC_W) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DAC_W - 1);

  logic [c_DIV_W-1:0] r_div;
  logic [c_BIT_W-1:0] r_bit;
  logic               r_high;     // current SCLK half-period is the high one
  logic               w_div_end;
  logic               w_bit_last;

  assign w_div_end  = i_run && (r_div == c_DIV_LAST);
  assign w_bit_last = (r_bit == c_BIT_LAST);

  assign o_sclk_rise = w_div_end && !r_high;
  assign o_sclk_fall = w_div_end && r_high;
  assign o_last_bit  = o_sclk_fall && w_bit_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_high <= 1'b0;
    end else if (!i_run) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_high <= 1'b0;
    end else if (w_div_end) begin
      r_div  <= '0;
      r_high <= ~r_high;
      // A bit period ends on the falling half
      if (r_high) begin
        r_bit <= w_bit_last ? '0 : r_bit + 1'b1;
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule : spi_bit_timer
`default_nettype wire

// File: rtl/phase_dac_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_dac_serializer
//  Purpose  : Converts the feedback phase word (plus offset) into an
//             MSB-aligned DAC_W-bit word and shifts it out to an SPI DAC.
//             Frame: LOAD (1 cycle) -> SHIFT (2*CLK_DIV*DAC_W cycles) ->
//             HOLD (CS_HOLD cycles, CS high) -> o_done pulse back in IDLE.
//             Strobes arriving while busy are kept in a one-deep pending
//             register; overwriting a pending word sets sticky o_overrun.
//  Ports    : i_clk   sole clock, rising edge
//             i_rst   asynchronous active-high reset
//             bus     phase_dac_serializer_if.slave (phase input, enable,
//                     SPI pins, busy/done/overrun status, last word)
//  Revision : 1.0 - initial release
// ============================================================================
module phase_dac_serializer
  import phase_dac_serializer_pkg::*;
#(
  parameter int DAC_W   = c_DEF_DAC_W,    // 1..32
  parameter int CLK_DIV = c_DEF_CLK_DIV,  // 1..255
  parameter int CS_HOLD = c_DEF_CS_HOLD   // >= 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  phase_dac_serializer_if.slave bus
);

  localparam int c_HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(CS_HOLD - 1);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [c_PHASE_W-1:0] w_sum;
  logic [DAC_W-1:0]     w_word;
  logic                 w_unused_sum;

  logic                 w_start;
  logic [DAC_W-1:0]     w_start_word;
  logic                 w_hold_end;
  logic                 w_run;
  logic                 w_sclk_rise;
  logic                 w_sclk_fall;
  logic                 w_last_bit;

  logic                 r_pend_valid;
  logic [DAC_W-1:0]     r_pend_word;
  logic [DAC_W-1:0]     r_shreg;
  logic [DAC_W-1:0]     r_word_act;
  logic [DAC_W-1:0]     r_dac_word;
  logic [c_HOLD_W-1:0]  r_hold;
  logic                 r_sclk;
  logic                 r_cs_n;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overrun;

  // --------------------------------------------------------------------------
  // Word formation: wrap-around add, keep the top DAC_W bits
  // --------------------------------------------------------------------------
  assign w_sum        = phase_add(bus.i_phaseRamp, bus.i_dac_offset);
  assign w_word       = w_sum[c_PHASE_W-1 -: DAC_W];
  // Lower sum bits are intentionally discarded by the truncation
  assign w_unused_sum = ^w_sum;

  // --------------------------------------------------------------------------
  // SCLK timing
  // --------------------------------------------------------------------------
  assign w_run = (r_state == ST_SHIFT);

  spi_bit_timer #(
    .DAC_W   (DAC_W),
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_run       (w_run),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_last_bit  (w_last_bit)
  );

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_start_word = r_pend_word;
    w_hold_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A fresh strobe takes priority over a pending word
        if (bus.i_dac_en && (bus.i_ramp_sync || r_pend_valid)) begin
          w_start      = 1'b1;
          w_start_word = bus.i_ramp_sync ? w_word : r_pend_word;
          w_state_nxt  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hold == c_HOLD_LAST) begin
          w_hold_end  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pending word and overrun flag
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend_valid <= 1'b0;
      r_pend_word  <= '0;
      r_overrun    <= 1'b0;
    end else if (!bus.i_dac_en) begin
      // Disabled: strobes are ignored and any queued word is discarded
      r_pend_valid <= 1'b0;
    end else if (bus.i_ramp_sync && (r_state != ST_IDLE)) begin
      r_pend_word  <= w_word;
      r_pend_valid <= 1'b1;
      if (r_pend_valid) begin
        r_overrun <= 1'b1;
      end
    end else if (w_start) begin
      r_pend_valid <= 1'b0;
      // Strobe in IDLE with a word still queued: the queued word is lost
      if (bus.i_ramp_sync && r_pend_valid) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, SPI pins, hold counter, status
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg    <= '0;
      r_word_act <= '0;
      r_dac_word <= '0;
      r_hold     <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_start) begin
        r_shreg    <= w_start_word;
        r_word_act <= w_start_word;
      end else if (w_sclk_fall) begin
        // SDI advances together with the falling SCLK edge
        r_shreg <= r_shreg << 1;
      end

      if (w_sclk_rise) begin
        r_sclk <= 1'b1;
      end else if (w_sclk_fall) begin
        r_sclk <= 1'b0;
      end

      if (r_state == ST_HOLD) begin
        r_hold <= r_hold + 1'b1;
      end else begin
        r_hold <= '0;
      end

      r_cs_n <= !((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT));
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_hold_end;

      if (w_hold_end) begin
        r_dac_word <= r_word_act;
      end
    end
  end

  assign bus.o_dac_sclk = r_sclk;
  assign bus.o_dac_sdi  = r_shreg[DAC_W-1];
  assign bus.o_dac_cs_n = r_cs_n;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;
  assign bus.o_overrun  = r_overrun;
  assign bus.o_dac_word = r_dac_word;

endmodule : phase_dac_serializer
`default_nettype wire

// File: tb/tb_phase_dac_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phase_dac_serializer
//  Purpose  : Self-checking bench for phase_dac_serializer (DAC_W=16,
//             CLK_DIV=2, CS_HOLD=4): directed vector table plus hand-written
//             multi-frame sequences (queueing, overrun, enable, reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phase_dac_serializer;

  localparam int c_FRAME_LEN   = 70;   // 2 + 2*2*16 + 4
  localparam int c_CS_LOW      = 65;   // LOAD + 64 SHIFT cycles
  localparam int c_BUSY_CYC    = 69;   // LOAD, SHIFT and HOLD
  localparam int c_FRAME_LIMIT = 200;

  typedef struct {
    logic [31:0] ramp;
    logic [31:0] off;
    logic        en;
    logic [15:0] exp_word;   // o_dac_word after the vector
  } vec_t;

  typedef struct {
    int          t_start;
    int          t_done;
    int          nbits;
    int          cs_low;
    int          busy_cnt;
    logic [15:0] bits;
    logic [15:0] word;
  } frame_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  phase_dac_serializer_if #(.DAC_W(16)) bus ();

  phase_dac_serializer #(
    .DAC_W   (16),
    .CLK_DIV (2),
    .CS_HOLD (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Raise the strobe for the current cycle (caller is at a falling edge)
  task automatic pulse_sync(input logic [31:0] ramp, input logic [31:0] off);
    bus.i_phaseRamp  = ramp;
    bus.i_dac_offset = off;
    bus.i_ramp_sync  = 1'b1;
    @(negedge clk);
    bus.i_ramp_sync  = 1'b0;
  endtask

  // Follow one frame, cycle k=1 being the cycle after the call, until o_done
  task automatic wait_frame(output frame_t f);
    logic prev_sclk;
    f.t_start  = -1;
    f.t_done   = -1;
    f.nbits    = 0;
    f.cs_low   = 0;
    f.busy_cnt = 0;
    f.bits     = '0;
    f.word     = '0;
    prev_sclk  = bus.o_dac_sclk;
    for (int k = 1; k <= c_FRAME_LIMIT; k++) begin
      @(negedge clk);
      if (!bus.o_dac_cs_n) begin
        f.cs_low++;
        if (f.t_start < 0) f.t_start = k;
      end
      if (bus.o_busy) f.busy_cnt++;
      if (bus.o_dac_sclk && !prev_sclk) begin
        f.bits = {f.bits[14:0], bus.o_dac_sdi};
        f.nbits++;
      end
      prev_sclk = bus.o_dac_sclk;
      if (bus.o_done) begin
        f.t_done = k;
        f.word   = bus.o_dac_word;
        break;
      end
    end
  endtask

  task automatic run_frame(input logic [31:0] ramp, input logic [31:0] off, output frame_t f);
    frame_t ft;
    fork
      pulse_sync(ramp, off);
      wait_frame(ft);
    join
    f = ft;
  endtask

  task automatic check_frame(input string tag, input frame_t f, input logic [15:0] exp_word);
    check({tag, ".start"},  f.t_start,  1);
    check({tag, ".done_at"}, f.t_done,  c_FRAME_LEN);
    check({tag, ".nbits"},  f.nbits,    16);
    check({tag, ".sdi"},    f.bits,     exp_word);
    check({tag, ".cs_low"}, f.cs_low,   c_CS_LOW);
    check({tag, ".busy"},   f.busy_cnt, c_BUSY_CYC);
    check({tag, ".word"},   f.word,     exp_word);
  endtask

  task automatic watch_idle(input int n, output int act_cnt, output int done_cnt);
    act_cnt  = 0;
    done_cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.o_busy || !bus.o_dac_cs_n) act_cnt++;
      if (bus.o_done) done_cnt++;
    end
  endtask

  vec_t   vecs [7];
  frame_t fa;
  frame_t fb;
  int     act_cnt;
  int     done_cnt;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 16'h1234};
    vecs[1] = '{32'hFFFF_8000, 32'h0001_0000, 1'b1, 16'h0000};  // wraps
    vecs[2] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 16'h0001};  // carry into top half
    vecs[3] = '{32'hA5A5_0000, 32'h0F0F_0000, 1'b1, 16'hB4B4};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 16'h8000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 16'hFFFF};
    vecs[6] = '{32'h5555_0000, 32'h0000_0000, 1'b0, 16'hFFFF};  // disabled: word unchanged

    rst              = 1'b1;
    bus.i_phaseRamp  = '0;
    bus.i_dac_offset = '0;
    bus.i_ramp_sync  = 1'b0;
    bus.i_dac_en     = 1'b1;

    repeat (2) @(negedge clk);
    check("reset.outputs",
          {25'd0, bus.o_dac_sclk, bus.o_dac_sdi, bus.o_dac_cs_n, bus.o_busy, bus.o_done, bus.o_overrun, 1'b0},
          {25'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check("reset.word", bus.o_dac_word, 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- directed vector table ----------------
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].en) begin
        run_frame(vecs[i].ramp, vecs[i].off, fa);
        check_frame($sformatf("vec%0d", i), fa, vecs[i].exp_word);
      end else begin
        bus.i_dac_en = 1'b0;
        pulse_sync(vecs[i].ramp, vecs[i].off);
        watch_idle(80, act_cnt, done_cnt);
        bus.i_dac_en = 1'b1;
        check($sformatf("vec%0d.no_frame", i), act_cnt, 0);
        check($sformatf("vec%0d.no_done", i), done_cnt, 0);
        check($sformatf("vec%0d.word", i), bus.o_dac_word, vecs[i].exp_word);
      end
      repeat (3) @(negedge clk);
    end

    // ---------------- strobe B queued behind A ----------------
    fork
      begin
        pulse_sync(32'h1111_0000, 32'h0);
        repeat (9) @(negedge clk);
        pulse_sync(32'h2000_0000, 32'h0222_0000);
      end
      wait_frame(fa);
    join
    wait_frame(fb);
    check_frame("queue.A", fa, 16'h1111);
    check_frame("queue.B", fb, 16'h2222);
    check("queue.overrun", bus.o_overrun, 1'b0);
    repeat (3) @(negedge clk);

    // ---------------- enable dropped mid-frame ----------------
    fork
      begin
        pulse_sync(32'h4444_0000, 32'h0);
        repeat (9) @(negedge clk);
        bus.i_dac_en = 1'b0;
      end
      wait_frame(fa);
    join
    bus.i_dac_en = 1'b1;
    check_frame("en_mid", fa, 16'h4444);
    repeat (3) @(negedge clk);

    // ---------------- enable pulse low discards the pending word ----------------
    fork
      begin
        pulse_sync(32'h5151_0000, 32'h0);
        repeat (9) @(negedge clk);
        pulse_sync(32'h5252_0000, 32'h0);
        repeat (19) @(negedge clk);
        bus.i_dac_en = 1'b0;
        @(negedge clk);
        bus.i_dac_en = 1'b1;
      end
      wait_frame(fa);
    join
    check_frame("en_drop.A", fa, 16'h5151);
    watch_idle(80, act_cnt, done_cnt);
    check("en_drop.no_B", act_cnt, 0);
    check("en_drop.overrun", bus.o_overrun, 1'b0);

    // ---------------- A, B, C in one frame: C follows, overrun set ----------------
    fork
      begin
        pulse_sync(32'h6161_0000, 32'h0);
        repeat (9) @(negedge clk);
        pulse_sync(32'h6262_0000, 32'h0);
        repeat (9) @(negedge clk);
        pulse_sync(32'h6363_0000, 32'h0);
      end
      wait_frame(fa);
    join
    wait_frame(fb);
    check_frame("ovr.A", fa, 16'h6161);
    check_frame("ovr.C", fb, 16'h6363);
    check("ovr.flag", bus.o_overrun, 1'b1);
    watch_idle(40, act_cnt, done_cnt);
    check("ovr.sticky", bus.o_overrun, 1'b1);
    check("ovr.no_extra", act_cnt, 0);

    // ---------------- reset at cycle 20 of a frame ----------------
    pulse_sync(32'h7777_0000, 32'h0);
    repeat (19) @(negedge clk);
    check("rst_mid.cs_before", bus.o_dac_cs_n, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_mid.cs_async", bus.o_dac_cs_n, 1'b1);
    check("rst_mid.busy", bus.o_busy, 1'b0);
    check("rst_mid.sclk", bus.o_dac_sclk, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch_idle(80, act_cnt, done_cnt);
    check("rst_mid.no_done", done_cnt, 0);
    check("rst_mid.idle", act_cnt, 0);
    check("rst_mid.overrun", bus.o_overrun, 1'b0);
    check("rst_mid.word", bus.o_dac_word, 16'h0000);
    run_frame(32'h8888_0000, 32'h0, fa);
    check_frame("rst_after", fa, 16'h8888);
    repeat (3) @(negedge clk);

    // ---------------- strobe in the IDLE-return cycle with a word pending ----------------
    fork
      begin
        pulse_sync(32'h9191_0000, 32'h0);
        repeat (9) @(negedge clk);
        pulse_sync(32'h9292_0000, 32'h0);
      end
      wait_frame(fa);
    join
    check("ret.overrun_before", bus.o_overrun, 1'b0);
    fork
      pulse_sync(32'h9393_0000, 32'h0);
      wait_frame(fb);
    join
    check_frame("ret.A", fa, 16'h9191);
    check_frame("ret.C", fb, 16'h9393);
    check("ret.overrun", bus.o_overrun, 1'b1);
    watch_idle(80, act_cnt, done_cnt);
    check("ret.B_dropped", act_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_phase_dac_serializer
`default_nettype wire
